// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU datapath: instruction field positions,
// the ALU control bundle, jump encodings and the reset program counter.
package hack_pkg;

    localparam int unsigned WORD_W = 16;

    // Instruction field bit positions
    localparam int unsigned INST_TYPE_BIT = 15;
    localparam int unsigned A_M_SEL_BIT   = 12;
    localparam int unsigned CTRL_HI       = 11;
    localparam int unsigned CTRL_LO       = 6;
    localparam int unsigned DEST_A_BIT    = 5;
    localparam int unsigned DEST_D_BIT    = 4;
    localparam int unsigned DEST_M_BIT    = 3;
    localparam int unsigned JUMP_HI       = 2;
    localparam int unsigned JUMP_LO       = 0;

    localparam int unsigned CTRL_W = CTRL_HI - CTRL_LO + 1;
    localparam int unsigned JUMP_W = JUMP_HI - JUMP_LO + 1;

    localparam logic [WORD_W-1:0] RESET_PC = 16'h0000;

    // ALU control bundle, field order matches instruction[11:6]
    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } alu_ctrl_t;

    // Jump condition encodings, instruction[2:0]
    typedef enum logic [2:0] {
        JNULL = 3'b000,
        JGT   = 3'b001,
        JEQ   = 3'b010,
        JGE   = 3'b011,
        JLT   = 3'b100,
        JNE   = 3'b101,
        JLE   = 3'b110,
        JMP   = 3'b111
    } jump_e;

endpackage

// File: rtl/hack_alu.sv
// Hack ALU: purely combinational x/y conditioning, add/and, optional output
// inversion, plus zero and negative flags.
module hack_alu
    import hack_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  alu_ctrl_t        ctrl,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng
);

    logic [WIDTH-1:0] x_z;
    logic [WIDTH-1:0] x_n;
    logic [WIDTH-1:0] y_z;
    logic [WIDTH-1:0] y_n;
    logic [WIDTH-1:0] f_out;

    // Operand conditioning: zero first, then invert
    always_comb begin
        x_z = ctrl.zx ? '0 : x;
        x_n = ctrl.nx ? ~x_z : x_z;
        y_z = ctrl.zy ? '0 : y;
        y_n = ctrl.ny ? ~y_z : y_z;
    end

    // Function select, output inversion and flags
    always_comb begin
        f_out = ctrl.f ? (x_n + y_n) : (x_n & y_n);
        out   = ctrl.no ? ~f_out : f_out;
        zr    = (out == '0);
        ng    = out[WIDTH-1];
    end

endmodule

// File: rtl/hack_datapath.sv
// Hack CPU datapath: A, D and PC registers, instruction decode, jump logic
// and the hack_alu instance. One instruction executes per clock.
// Optional build macro: HACK_DATAPATH_TRACE_EN prints a per-edge trace.
// outM and writeM are combinational by definition of the Hack memory port.
module hack_datapath
    import hack_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] instruction,
    input  logic [WIDTH-1:0] inM,
    output logic [WIDTH-1:0] outM,
    output logic             writeM,
    output logic [WIDTH-1:0] addressM,
    output logic [WIDTH-1:0] newPC
);

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] pc_reg;

    logic             is_c;
    alu_ctrl_t        alu_ctrl;
    logic [WIDTH-1:0] alu_y;
    logic [WIDTH-1:0] alu_out;
    logic             alu_zr;
    logic             alu_ng;
    jump_e            jump_code;
    logic             jump_cond;
    logic             pc_load;
    logic             load_a;
    logic             load_d;
    logic [WIDTH-1:0] a_next;

    // Field decode and ALU operand select
    always_comb begin
        is_c      = instruction[INST_TYPE_BIT];
        alu_ctrl  = alu_ctrl_t'(instruction[CTRL_HI:CTRL_LO]);
        alu_y     = instruction[A_M_SEL_BIT] ? inM : a_reg;
        jump_code = jump_e'(instruction[JUMP_HI:JUMP_LO]);
    end

    hack_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .x    (d_reg),
        .y    (alu_y),
        .ctrl (alu_ctrl),
        .out  (alu_out),
        .zr   (alu_zr),
        .ng   (alu_ng)
    );

    // Jump condition from the ALU flags
    always_comb begin
        jump_cond = 1'b0;
        case (jump_code)
            JNULL:   jump_cond = 1'b0;
            JGT:     jump_cond = !alu_ng && !alu_zr;
            JEQ:     jump_cond = alu_zr;
            JGE:     jump_cond = !alu_ng;
            JLT:     jump_cond = alu_ng;
            JNE:     jump_cond = !alu_zr;
            JLE:     jump_cond = alu_ng || alu_zr;
            JMP:     jump_cond = 1'b1;
            default: jump_cond = 1'b0;
        endcase
        pc_load = is_c && jump_cond;
    end

    // Destination decode; A-instructions always load A with a 15-bit constant
    always_comb begin
        load_a = !is_c || instruction[DEST_A_BIT];
        load_d = is_c && instruction[DEST_D_BIT];
        a_next = is_c ? alu_out : {1'b0, instruction[WIDTH-2:0]};
    end

    // Memory-side outputs; the write strobe is suppressed during reset
    always_comb begin
        outM     = alu_out;
        writeM   = reset && is_c && instruction[DEST_M_BIT];
        addressM = a_reg;
        newPC    = pc_reg;
    end

    // A and D registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_reg <= '0;
            d_reg <= '0;
        end else begin
            if (load_a) a_reg <= a_next;
            if (load_d) d_reg <= alu_out;
        end
    end

    // Program counter: jump target is the A value from before this edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_reg <= WIDTH'(RESET_PC);
        end else if (pc_load) begin
            pc_reg <= a_reg;
        end else begin
            pc_reg <= pc_reg + WIDTH'(1);
        end
    end

`ifdef HACK_DATAPATH_TRACE_EN
    // Per-edge execution trace
    always @(posedge clk) begin
        if (reset) begin
            $display("hack_datapath: pc=%h a=%h d=%h x=%h y=%h res=%h ldA=%b ldD=%b wrM=%b jmp=%b",
                     pc_reg, a_reg, d_reg, d_reg, alu_y, alu_out,
                     load_a, load_d, writeM, pc_load);
        end
    end
`else
    // Trace disabled: no additional logic
`endif

endmodule

// File: tb/tb_hack_datapath.sv
// Self-checking bench for hack_datapath: directed Hack programs with literal
// expectations, then randomized instructions and reset pulses, all checked
// every cycle against an arithmetic reference model.
module tb_hack_datapath;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] instruction = 16'hE308;
    logic [15:0] inM = 16'h0000;
    logic [15:0] outM;
    logic        writeM;
    logic [15:0] addressM;
    logic [15:0] newPC;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    hack_datapath #(.WIDTH(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .inM         (inM),
        .outM        (outM),
        .writeM      (writeM),
        .addressM    (addressM),
        .newPC       (newPC)
    );

    always #5 clk = ~clk;

    // Reference ALU in plain integer arithmetic (~v written as 65535 - v)
    function automatic logic [15:0] ref_alu(input logic [15:0] x, input logic [15:0] y,
                                            input logic [5:0] c);
        int unsigned xv = x;
        int unsigned yv = y;
        int unsigned r;
        if (c[5]) xv = 0;
        if (c[4]) xv = 65535 - xv;
        if (c[3]) yv = 0;
        if (c[2]) yv = 65535 - yv;
        r = c[1] ? (xv + yv) % 65536 : (xv & yv);
        if (c[0]) r = 65535 - r;
        return 16'(r);
    endfunction

    // Jump decision as a signed comparison against zero
    function automatic bit ref_jump(input logic [15:0] res, input logic [2:0] j);
        int v = int'($signed(res));
        return (j[2] && v < 0) || (j[1] && v == 0) || (j[0] && v > 0);
    endfunction

    logic [15:0] m_a, m_d, m_pc;
    logic [15:0] m_res;
    assign m_res = ref_alu(m_d, instruction[12] ? inM : m_a, instruction[11:6]);

    // Reference machine state
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_a  <= 16'h0000;
            m_d  <= 16'h0000;
            m_pc <= 16'h0000;
        end else if (!instruction[15]) begin
            m_a  <= {1'b0, instruction[14:0]};
            m_pc <= m_pc + 16'd1;
        end else begin
            if (instruction[5]) m_a <= m_res;
            if (instruction[4]) m_d <= m_res;
            m_pc <= ref_jump(m_res, instruction[2:0]) ? m_a : m_pc + 16'd1;
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%04h, expected 0x%04h (t=%0t)", name, act, exp, $time);
    endtask

    // Every-cycle comparison against the reference model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_outM", outM, m_res);
            chk("model_writeM", {15'd0, writeM},
                {15'd0, reset & instruction[15] & instruction[3]});
            chk("model_addressM", addressM, m_a);
            chk("model_newPC", newPC, m_pc);
        end
    end

    task automatic exec(input logic [15:0] i, input logic [15:0] m);
        instruction = i;
        inM = m;
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset held with a memory-write instruction presented
        repeat (2) @(posedge clk);
        #2;
        chk_en = 1'b1;
        #1;
        chk("rst_newPC", newPC, 16'h0000);
        chk("rst_addressM", addressM, 16'h0000);
        chk("rst_writeM", {15'd0, writeM}, 16'h0000);

        reset = 1'b1;
        exec(16'h0000, 16'h0000); chk("pc_step1", newPC, 16'd1);
        exec(16'h0000, 16'h0000); chk("pc_step2", newPC, 16'd2);
        exec(16'h0000, 16'h0000); chk("pc_step3", newPC, 16'd3);

        // Load and copy
        exec(16'h0005, 16'h0000); chk("at5_addressM", addressM, 16'd5);
        exec(16'hEC10, 16'h0000);
        instruction = 16'hE308; #1;
        chk("m_eq_d_outM", outM, 16'd5);
        chk("m_eq_d_writeM", {15'd0, writeM}, 16'd1);
        exec(16'hE308, 16'h0000); chk("m_eq_d_newPC", newPC, 16'd6);

        // Memory add
        exec(16'h0007, 16'h0000); chk("at7_addressM", addressM, 16'd7);
        instruction = 16'hF090; inM = 16'd10; #1;
        chk("dplusm_outM", outM, 16'd15);
        chk("dplusm_writeM", {15'd0, writeM}, 16'd0);
        exec(16'hF090, 16'd10);
        instruction = 16'hE308; #1;
        chk("dplusm_D", outM, 16'd15);

        // Unconditional jump
        exec(16'h0064, 16'h0000);
        exec(16'hEA87, 16'h0000); chk("jmp_newPC", newPC, 16'd100);

        // Conditional jumps with A=100
        exec(16'hEA90, 16'h0000);
        exec(16'hE301, 16'h0000); chk("jgt_not_taken", newPC, 16'd102);
        exec(16'hEE90, 16'h0000);
        exec(16'hE304, 16'h0000); chk("jlt_taken", newPC, 16'd100);

        // Jump uses the old A even when the same instruction writes A
        exec(16'hEDE7, 16'h0000);
        chk("jmp_old_a_newPC", newPC, 16'd100);
        chk("jmp_old_a_addressM", addressM, 16'd101);

        // PC wrap from 0xFFFF
        exec(16'hEEA0, 16'h0000);
        exec(16'hEA87, 16'h0000); chk("pc_ffff", newPC, 16'hFFFF);
        exec(16'h0000, 16'h0000); chk("pc_wrap", newPC, 16'h0000);

        // Asynchronous reset between edges, then abort of the pending instruction
        exec(16'h0123, 16'h0000);
        exec(16'hEE90, 16'h0000);
        reset = 1'b0; #1;
        chk("arst_addressM", addressM, 16'h0000);
        chk("arst_newPC", newPC, 16'h0000);
        instruction = 16'hE308; #1;
        chk("arst_D", outM, 16'h0000);
        chk("arst_writeM", {15'd0, writeM}, 16'h0000);
        instruction = 16'h0042;
        @(posedge clk); #2;
        reset = 1'b1; #1;
        chk("abort_addressM", addressM, 16'h0000);
        chk("abort_newPC", newPC, 16'h0000);
        exec(16'h0042, 16'h0000);
        chk("post_rst_addressM", addressM, 16'h0042);
        chk("post_rst_newPC", newPC, 16'd1);

        // Randomized programs with occasional mid-cycle reset pulses
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) < 4)
                instruction = {1'b0, 15'($urandom)};
            else
                instruction = {3'b111, 13'($urandom)};
            inM = 16'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b0;
                #5;
                reset = 1'b1;
                @(posedge clk);
                #2;
            end else begin
                @(posedge clk);
                #2;
            end
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
